// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC select, fetch handshake, redirect flush window, misalign halt/trap; PC_FETCH_STATS_EN adds branch counters
module pc_fetch_ctrl #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int FLUSH_SLOTS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_branch,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            stall,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            if_ready,
`ifdef PC_FETCH_STATS_EN
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken,
`endif
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            flush,
  output logic            misalign
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  localparam logic [2:0] SLOTS = 3'(FLUSH_SLOTS);
  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            redir, run;
  logic [XLEN-1:0] tgt;
  assign run      = state_q == RUN;
  assign redir    = jump | (ex_branch & br_taken);
  assign tgt      = jump ? jump_target : br_target;
  assign if_valid = valid_q;
  assign if_pc    = pc_q;
  assign pc_plus4 = pc_q + XLEN'(4);
  assign flush    = |cnt_q;
  assign misalign = mis_q;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    cnt_d   = flush ? cnt_q - 3'd1 : cnt_q;
    if (state_q == BOOT) begin
      state_d = RUN;
      valid_d = 1'b1;
    end else if (trap) begin
      state_d = RUN;
      valid_d = 1'b1;
      pc_d    = trap_vec;
      mis_d   = 1'b0;
      cnt_d   = SLOTS;
    end else if (run && redir && tgt[1:0] != 2'b00) begin
      // misaligned target: freeze PC and wait for the trap controller
      state_d = HALT;
      valid_d = 1'b0;
      mis_d   = 1'b1;
    end else if (run && redir) begin
      pc_d  = tgt;
      cnt_d = SLOTS;
    end else if (run && !stall && valid_q && if_ready) begin
      pc_d = pc_q + XLEN'(4);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef PC_FETCH_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d, tk_cnt_q, tk_cnt_d;
  assign stat_branches = br_cnt_q;
  assign stat_taken    = tk_cnt_q;
  always_comb begin
    br_cnt_d = br_cnt_q + 32'(run & ex_branch);
    tk_cnt_d = tk_cnt_q + 32'(run & ex_branch & br_taken);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      tk_cnt_q <= tk_cnt_d;
    end
  end
`endif
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_branch = 1'b0, br_taken = 1'b0, jump = 1'b0, stall = 1'b0, trap = 1'b0, if_ready = 1'b1;
  logic [31:0] br_target = '0, jump_target = '0, trap_vec = '0;
  logic        if_valid, flush, misalign;
  logic [31:0] if_pc, pc_plus4;
`ifdef PC_FETCH_STATS_EN
  logic [31:0] stat_branches, stat_taken;
`endif
  int n_checks = 0;
  int n_errors = 0;
  always #5 clk = ~clk;
  pc_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ex_branch(ex_branch), .br_taken(br_taken), .br_target(br_target),
    .jump(jump), .jump_target(jump_target), .stall(stall), .trap(trap), .trap_vec(trap_vec),
    .if_ready(if_ready),
`ifdef PC_FETCH_STATS_EN
    .stat_branches(stat_branches), .stat_taken(stat_taken),
`endif
    .if_valid(if_valid), .if_pc(if_pc), .pc_plus4(pc_plus4), .flush(flush), .misalign(misalign)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    ex_branch = 0; br_taken = 0; jump = 0; stall = 0; trap = 0; if_ready = 1;
  endtask
  task automatic st(input string tag, input logic [31:0] pc, input logic v, input logic f, input logic m);
    check({tag, ".pc"}, if_pc, pc);
    check({tag, ".valid"}, 32'(if_valid), 32'(v));
    check({tag, ".flush"}, 32'(flush), 32'(f));
    check({tag, ".mis"}, 32'(misalign), 32'(m));
  endtask
  initial begin
    repeat (3) tick();
    st("reset", 32'h0, 0, 0, 0);
    rst_n = 1;
    st("boot", 32'h0, 0, 0, 0);
    tick(); st("run0", 32'h0, 1, 0, 0);
    tick(); st("run4", 32'h4, 1, 0, 0);
    tick(); st("run8", 32'h8, 1, 0, 0);
    check("plus4_8", pc_plus4, 32'hC);
    if_ready = 0;
    tick(); st("bp1", 32'h8, 1, 0, 0);
    tick(); st("bp2", 32'h8, 1, 0, 0);
    if_ready = 1; stall = 1;
    tick(); st("stall", 32'h8, 1, 0, 0);
    stall = 0;
    tick(); st("resume", 32'hC, 1, 0, 0);
    ex_branch = 1; br_taken = 1; br_target = 32'h100; stall = 1;
    tick(); st("br_tk", 32'h100, 1, 1, 0);
    idle();
    tick(); st("br_f2", 32'h104, 1, 1, 0);
    tick(); st("br_f0", 32'h108, 1, 0, 0);
    ex_branch = 1; br_taken = 0;
    tick(); st("br_nt", 32'h10C, 1, 0, 0);
    jump = 1; jump_target = 32'h200; ex_branch = 1; br_taken = 1; br_target = 32'h300;
    tick(); st("jmp_win", 32'h200, 1, 1, 0);
    ex_branch = 0; br_taken = 0; jump_target = 32'h400;
    tick(); st("reload", 32'h400, 1, 1, 0);
    idle();
    tick(); st("reload_f3", 32'h404, 1, 1, 0);
    tick(); st("reload_end", 32'h408, 1, 0, 0);
    ex_branch = 1; br_taken = 1; br_target = 32'h102;
    tick(); st("misal", 32'h408, 0, 0, 1);
    idle(); jump = 1; jump_target = 32'h500;
    tick(); st("halt_jmp", 32'h408, 0, 0, 1);
    idle(); trap = 1; trap_vec = 32'h80;
    tick(); st("trap", 32'h80, 1, 1, 0);
    trap = 0;
    tick(); st("trap_f2", 32'h84, 1, 1, 0);
    tick(); st("trap_end", 32'h88, 1, 0, 0);
    jump = 1; jump_target = 32'h600;
    tick(); st("pre_rst", 32'h600, 1, 1, 0);
    jump = 0;
    #2 rst_n = 0;
    #1 st("async_rst", 32'h0, 0, 0, 0);
    tick(); rst_n = 1;
    st("reboot", 32'h0, 0, 0, 0);
    tick(); st("rerun", 32'h0, 1, 0, 0);
    jump = 1; jump_target = 32'hFFFF_FFFC;
    tick(); st("to_top", 32'hFFFF_FFFC, 1, 1, 0);
    check("plus4_wrap", pc_plus4, 32'h0);
    jump = 0;
    tick(); st("wrap", 32'h0, 1, 1, 0);
    check("plus4_0", pc_plus4, 32'h4);
    ex_branch = 1; br_taken = 1; br_target = 32'h1000;
    tick(); check("b1", if_pc, 32'h1000);
    br_taken = 0;
    tick(); check("b2", if_pc, 32'h1004);
    br_taken = 1; br_target = 32'h2000;
    tick(); check("b3", if_pc, 32'h2000);
    br_taken = 0;
    tick(); check("b4", if_pc, 32'h2004);
    br_taken = 1; br_target = 32'h3000;
    tick(); check("b5", if_pc, 32'h3000);
    idle();
    tick();
`ifdef PC_FETCH_STATS_EN
    check("stat_br", stat_branches, 32'd5);
    check("stat_tk", stat_taken, 32'd3);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter and fetch-request stage directly downstream of the branch resolution unit.
- Consumes the resolved `taken` decision and jump requests and drives the PC toward instruction memory.
- Owns sequential next-PC selection, the fetch valid/ready handshake, the younger-instruction flush window after a redirect, and the misaligned-target halt/trap sequence.

Parameters:
- XLEN, 32, PC and target width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FLUSH_SLOTS, 2, cycles `flush` stays high after a redirect (range 1..7).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_branch  in  1  instruction in EX is a conditional branch (resolution valid this cycle).
- br_taken  in  1  `taken` from the branch unit; qualified by ex_branch.
- br_target  in  XLEN  branch target address.
- jump  in  1  jal/jalr redirect request this cycle.
- jump_target  in  XLEN  jump target address.
- stall  in  1  hold PC (hazard stall).
- trap  in  1  trap controller accepts pending exception.
- trap_vec  in  XLEN  trap handler address.
- if_ready  in  1  instruction memory accepts request.
- if_valid  out  1  fetch request valid.
- if_pc  out  XLEN  current fetch address.
- pc_plus4  out  XLEN  if_pc + 4 (link value).
- flush  out  1  kill younger in-flight instructions.
- misalign  out  1  redirect target not 4-byte aligned (sticky until trap).

Behaviour:
- Reset (async, rst_n=0): state=BOOT, if_pc=RESET_PC, if_valid=0, flush=0, misalign=0, flush counter=0. Applies mid-operation in any state, including during a flush window.
- States: BOOT, RUN, HALT.
- BOOT: if_valid=0 for exactly one cycle after rst_n rises, then RUN. Redirect inputs are ignored in BOOT.
- RUN: if_valid=1. Each edge picks the next PC by priority; only the first matching rule applies:
  1. trap=1: if_pc<=trap_vec; load flush window.
  2. jump=1: target is jump_target.
  3. ex_branch & br_taken: target is br_target.
  4. stall=1: hold if_pc.
  5. if_valid & if_ready: if_pc<=if_pc+4, wrapping modulo 2^XLEN (32'hFFFF_FFFC -> 0).
  6. Otherwise hold (fetch not accepted; if_pc must stay stable while if_valid=1 and if_ready=0).
- Redirect (rules 2/3) overrides stall and does not wait on if_ready.
- Redirect with target[1:0]==0: if_pc<=target; flush counter loads FLUSH_SLOTS.
- Redirect with target[1:0]!=0: if_pc unchanged; misalign<=1; state->HALT; no flush.
- jump and ex_branch&br_taken together: jump wins. ex_branch & !br_taken: sequential rules apply.
- Flush window: flush=1 while counter!=0; counter decrements each cycle. A new redirect inside the window reloads the counter to FLUSH_SLOTS. Fetch continues from the new PC during the window.
- HALT: if_valid=0; if_pc frozen; misalign held at 1. Only trap=1 is accepted: if_pc<=trap_vec, misalign<=0, flush window loaded, state->RUN. jump/branch/stall are ignored in HALT.
- pc_plus4: combinational if_pc+4, XLEN-bit wrap.
- Latency: redirect is visible on if_pc the cycle after the request edge; flush rises in that same cycle.

Optional Feature:
- Macro: PC_FETCH_STATS_EN.
- Defined:
  - Adds outputs stat_branches [31:0] (increments when ex_branch=1 in RUN) and stat_taken [31:0] (increments when ex_branch & br_taken in RUN, including misaligned takens).
  - Both counters reset to 0, wrap at 2^32, and do not count in BOOT/HALT.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset/boot: rst_n low 3 cycles, release, if_ready=1 -> if_valid=0 one cycle, then if_pc 0x0, 0x4, 0x8 on successive cycles.
- Backpressure/stall: at if_pc=0x8 hold if_ready=0 two cycles, then stall=1 one cycle with if_ready=1 -> if_pc stays 0x8 for all three cycles, then 0xC.
- Taken branch plus stall: ex_branch=1, br_taken=1, br_target=0x100, stall=1 -> next if_pc=0x100, flush=1 for exactly 2 cycles. ex_branch=1, br_taken=0 -> if_pc+4, flush stays 0.
- Simultaneous/reload: jump=1 jump_target=0x200 with br_taken=1 br_target=0x300 -> if_pc=0x200. A second redirect to 0x400 on the next cycle -> flush stays high 2 more cycles (3 total).
- Misalign/trap: br_target=0x102 taken -> misalign=1, if_valid=0, if_pc frozen, jump ignored. trap=1 trap_vec=0x80 -> if_pc=0x80, misalign=0, flush 2 cycles. Separately, async rst_n low mid-flush -> immediate if_pc=RESET_PC, flush=0.
- Wrap and stats (PC_FETCH_STATS_EN): redirect to 0xFFFF_FFFC, accept fetch -> if_pc=0x0, pc_plus4=0x4. 5 branches with 3 taken -> stat_branches=5, stat_taken=3.
